// File: rtl/red_tracker_pkg.sv
// Shared widths, FSM state type and per-frame accumulator record for the
// red blob tracker.
package red_tracker_pkg;

    localparam int CNT_W   = 19;
    localparam int SUM_W   = 28;
    localparam int DIV_CYC = 28;
    localparam int COORD_W = 10;

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, PUBLISH} trk_state_t;

    typedef struct packed {
        logic [CNT_W-1:0]   cnt;
        logic [SUM_W-1:0]   sum_x;
        logic [SUM_W-1:0]   sum_y;
        logic [COORD_W-1:0] x_min;
        logic [COORD_W-1:0] x_max;
        logic [COORD_W-1:0] y_min;
        logic [COORD_W-1:0] y_max;
    } blob_acc_t;

    // Start-of-frame value: min at the top of the range so the first pixel wins.
    function automatic blob_acc_t acc_init();
        blob_acc_t a;
        a.cnt   = '0;
        a.sum_x = '0;
        a.sum_y = '0;
        a.x_min = '1;
        a.x_max = '0;
        a.y_min = '1;
        a.y_max = '0;
        return a;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock. The first bit is
// resolved in the start cycle so done lands DIV_CYC cycles after start.
module seq_divider
    import red_tracker_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);

    localparam int LEFT_W = $clog2(DIV_CYC);

    logic [CNT_W-1:0]  rem_q;
    logic [CNT_W-1:0]  div_q;
    logic [SUM_W-1:0]  dvd_q;
    logic [LEFT_W-1:0] left_q;
    logic              running;

    logic [CNT_W-1:0]  rem_in;
    logic [CNT_W-1:0]  div_in;
    logic [SUM_W-1:0]  dvd_in;
    logic [CNT_W:0]    trial;
    logic [CNT_W:0]    trial_diff;
    logic [CNT_W-1:0]  rem_step;
    logic              ge;

    // The dividend register shifts left and collects quotient bits at its LSB.
    always_comb begin
        rem_in     = start ? '0       : rem_q;
        dvd_in     = start ? dividend : dvd_q;
        div_in     = start ? divisor  : div_q;
        trial      = {rem_in, dvd_in[SUM_W-1]};
        trial_diff = trial - {1'b0, div_in};
        ge         = (trial >= {1'b0, div_in});
        rem_step   = ge ? trial_diff[CNT_W-1:0] : trial[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            done    <= 1'b0;
            left_q  <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            dvd_q   <= '0;
        end else begin
            done <= 1'b0;
            if (start || running) begin
                rem_q <= rem_step;
                dvd_q <= {dvd_in[SUM_W-2:0], ge};
                div_q <= div_in;
            end
            if (start) begin
                running <= 1'b1;
                left_q  <= LEFT_W'(DIV_CYC - 1);
            end else if (running) begin
                left_q <= left_q - LEFT_W'(1);
                if (left_q == LEFT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign quotient = dvd_q;

endmodule

// File: rtl/red_blob_tracker.sv
// Per-frame red pixel accumulator with centroid computation; publishes aim
// point and bounding box that hold steady for the following frame.
module red_blob_tracker
    import red_tracker_pkg::*;
#(
    parameter int unsigned H_ACT     = 640,
    parameter int unsigned V_ACT     = 480,
    parameter logic [3:0]  R_MIN     = 4'hA,
    parameter logic [3:0]  G_MAX     = 4'h5,
    parameter logic [3:0]  B_MAX     = 4'h5,
    parameter int unsigned MIN_COUNT = 64
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         de,
    input  logic [9:0]   x_pixel,
    input  logic [9:0]   y_pixel,
    input  logic [11:0]  pixel,
    input  logic         frame_end,
    output logic [9:0]   aim_x,
    output logic [9:0]   aim_y,
    output logic         aim_detected,
    output logic [11:0]  box_x_min,
    output logic [11:0]  box_x_max,
    output logic [11:0]  box_y_min,
    output logic [11:0]  box_y_max,
    output logic         result_valid,
    output logic         busy
);

    blob_acc_t          acc_q;
    blob_acc_t          acc_next;
    blob_acc_t          snap_q;
    trk_state_t         state;
    logic               is_red;
    logic               div_start;
    logic               div_done;
    logic [SUM_W-1:0]   div_dividend;
    logic [SUM_W-1:0]   div_quotient;
    logic [COORD_W-1:0] quot_x;
    logic               unused_quot_bits;

    assign is_red = de
                 && (32'(x_pixel) < H_ACT) && (32'(y_pixel) < V_ACT)
                 && (pixel[11:8] >= R_MIN)
                 && (pixel[7:4]  <= G_MAX)
                 && (pixel[3:0]  <= B_MAX);

    // acc_next already includes this cycle's pixel, so a red pixel coincident
    // with frame_end lands in the snapshot of the closing frame.
    always_comb begin
        acc_next = acc_q;
        if (is_red) begin
            acc_next.cnt   = acc_q.cnt + CNT_W'(1);
            acc_next.sum_x = acc_q.sum_x + SUM_W'(x_pixel);
            acc_next.sum_y = acc_q.sum_y + SUM_W'(y_pixel);
            if (x_pixel < acc_q.x_min) acc_next.x_min = x_pixel;
            if (x_pixel > acc_q.x_max) acc_next.x_max = x_pixel;
            if (y_pixel < acc_q.y_min) acc_next.y_min = y_pixel;
            if (y_pixel > acc_q.y_max) acc_next.y_max = y_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || frame_end) acc_q <= acc_init();
        else                    acc_q <= acc_next;
    end

    assign div_dividend = (state == DIV_Y) ? snap_q.sum_y : snap_q.sum_x;

    seq_divider u_divider (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (snap_q.cnt),
        .done     (div_done),
        .quotient (div_quotient)
    );

    assign unused_quot_bits = ^div_quotient[SUM_W-1:COORD_W];

    // frame_end outside IDLE only clears the accumulators; the result in flight continues.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            snap_q       <= acc_init();
            div_start    <= 1'b0;
            quot_x       <= '0;
            aim_x        <= '0;
            aim_y        <= '0;
            aim_detected <= 1'b0;
            box_x_min    <= '0;
            box_x_max    <= '0;
            box_y_min    <= '0;
            box_y_max    <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            div_start    <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_end) begin
                        snap_q <= acc_next;
                        busy   <= 1'b1;
                        if (32'(acc_next.cnt) < MIN_COUNT) begin
                            aim_detected <= 1'b0;
                            result_valid <= 1'b1;
                            state        <= PUBLISH;
                        end else begin
                            div_start <= 1'b1;
                            state     <= DIV_X;
                        end
                    end
                end
                DIV_X: begin
                    if (div_done) begin
                        quot_x    <= div_quotient[COORD_W-1:0];
                        div_start <= 1'b1;
                        state     <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    if (div_done) begin
                        aim_x        <= quot_x;
                        aim_y        <= div_quotient[COORD_W-1:0];
                        aim_detected <= 1'b1;
                        box_x_min    <= {2'b00, snap_q.x_min};
                        box_x_max    <= {2'b00, snap_q.x_max};
                        box_y_min    <= {2'b00, snap_q.y_min};
                        box_y_max    <= {2'b00, snap_q.y_max};
                        result_valid <= 1'b1;
                        state        <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
